// File: rtl/fp_add_normalize_round_pkg.sv
// ---------------------------------------------------------------------------
// fp_add_normalize_round_pkg
// Shared constants and types for the FP adder normalize/round back end.
//   EXP_W / FRAC_W : binary32 exponent and stored-fraction widths
//   SIG_W          : working significand {hidden, frac, G, R, S}
//   LZC_W          : width of a leading-zero count over SIG_W bits (0..SIG_W)
//   GUARD/ROUND/STICKY : bit indices of the rounding bits inside SIG_W
//   fp32_t         : packed sign/exponent/fraction view of a binary32 word
//   flags_t        : {overflow, underflow, inexact} status triple
// ---------------------------------------------------------------------------
package fp_add_normalize_round_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int SIG_W   = FRAC_W + 4;
  localparam int LZC_W   = $clog2(SIG_W + 1);
  localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
  localparam int EXP_INF = 2 * BIAS + 1;  // all-ones exponent: Inf/NaN

  localparam int GUARD  = 2;
  localparam int ROUND  = 1;
  localparam int STICKY = 0;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;

endpackage

// File: rtl/fp_lzc.sv
// ---------------------------------------------------------------------------
// fp_lzc
// Combinational leading-zero counter over the SIG_W-bit working significand.
// An all-zero input returns SIG_W.
//   value : significand to scan, MSB first
//   count : number of zero bits above the most significant one
// ---------------------------------------------------------------------------
module fp_lzc
  import fp_add_normalize_round_pkg::*;
(
  input  logic [SIG_W-1:0] value,
  output logic [LZC_W-1:0] count
);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    count = LZC_W'(SIG_W);
    // Scan upward; the highest set bit is the last one to write count.
    for (int i = 0; i < SIG_W; i++) begin
      if (value[i]) count = LZC_W'(SIG_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_normalize_round.sv
// ---------------------------------------------------------------------------
// fp_add_normalize_round
// Back end of the binary32 adder: adds/subtracts the aligned significands,
// normalizes with a leading-zero count, rounds to nearest-even and packs.
// Three pipeline stages (S1 add, S2 normalize, S3 round/pack) with a
// valid/ready handshake on both sides; one op per cycle.
//
// Build option: define FP_ADD_FLAGS_EN to add the out_flags port and the
// per-stage flag registers. Without it the flag logic is absent and the
// result path is unchanged.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_sign1, in_sign2  operand signs (sign2 already includes FSUB negation)
//   in_exp              common biased exponent (1..254)
//   in_sig1, in_sig2    significands {hidden, frac, G, R, S}; sig2 is aligned
//   in_special(_res)    upstream-resolved NaN/Inf/zero result, passed through
//   out_valid/out_ready output handshake
//   out_result          packed binary32 result
//   out_flags           {overflow, underflow, inexact} (FP_ADD_FLAGS_EN only)
// ---------------------------------------------------------------------------
module fp_add_normalize_round
  import fp_add_normalize_round_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign1,
  input  logic              in_sign2,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [SIG_W-1:0]  in_sig1,
  input  logic [SIG_W-1:0]  in_sig2,
  input  logic              in_special,
  input  logic [31:0]       in_special_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result
`ifdef FP_ADD_FLAGS_EN
  ,
  output logic [2:0]        out_flags
`endif
);

  typedef struct packed {
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp;
    logic [SIG_W:0]   sum;      // magnitude, bit SIG_W is the add carry
    logic             special;
    logic [31:0]      special_res;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W:0]   exp;      // may reach EXP_INF after a carry
    logic [SIG_W-1:0] sig;      // normalized, hidden bit at SIG_W-1
    logic             zero;     // exact zero or flushed underflow
    logic             special;
    logic [31:0]      special_res;
`ifdef FP_ADD_FLAGS_EN
    logic             uf;
`endif
  } s2_t;

  // ---------------- handshake -------------------------------------------
  // A stage loads when it is empty or the stage after it is loading.
  logic s1_v, s2_v, s3_v;
  logic s1_ld, s2_ld, s3_ld;

  assign s3_ld     = !s3_v || out_ready;
  assign s2_ld     = !s2_v || s3_ld;
  assign s1_ld     = !s1_v || s2_ld;
  assign in_ready  = s1_ld;
  assign out_valid = s3_v;

  // ---------------- S1: add / subtract ----------------------------------
  s1_t            s1;
  logic           eff_sub;
  logic [SIG_W:0] sum_add, diff, s1_sum_nx;
  logic           s1_sign_nx;

  always_comb begin
    eff_sub    = in_sign1 ^ in_sign2;
    sum_add    = {1'b0, in_sig1} + {1'b0, in_sig2};
    diff       = {1'b0, in_sig1} - {1'b0, in_sig2};
    s1_sign_nx = in_sign1;
    s1_sum_nx  = sum_add;
    if (eff_sub) begin
      // A borrow means sig2 was larger: keep the magnitude, take its sign.
      if (diff[SIG_W]) begin
        s1_sum_nx  = -diff;
        s1_sign_nx = in_sign2;
      end else begin
        s1_sum_nx  = diff;
      end
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every stage samples the previous stage's value from before this edge.
  // NOTE: payload registers are reset along with the valid bits; the packed
  // result must read zero out of reset and the stages are only a few words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1   <= '0;
    end else if (s1_ld) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1.sign        <= s1_sign_nx;
        s1.eff_sub     <= eff_sub;
        s1.exp         <= in_exp;
        s1.sum         <= s1_sum_nx;
        s1.special     <= in_special;
        s1.special_res <= in_special_res;
      end
    end
  end

  // ---------------- S2: normalize ---------------------------------------
  s2_t              s2;
  logic [LZC_W-1:0] lzc;
  logic [EXP_W+1:0] exp_norm;   // two spare bits: MSB set means below zero
  logic [SIG_W-1:0] sig_norm;
  logic             sum_zero, flush;

  fp_lzc u_lzc (
    .value (s1.sum[SIG_W-1:0]),
    .count (lzc)
  );

  always_comb begin
    sum_zero = (s1.sum == '0);
    if (s1.sum[SIG_W]) begin
      // Carry out: shift right one, fold the dropped bit into sticky.
      sig_norm = {s1.sum[SIG_W:2], s1.sum[1] | s1.sum[0]};
      exp_norm = {2'b00, s1.exp} + (EXP_W+2)'(1);
    end else begin
      sig_norm = s1.sum[SIG_W-1:0] << lzc;
      exp_norm = {2'b00, s1.exp} - {{(EXP_W+2-LZC_W){1'b0}}, lzc};
    end
    // Denormals are not produced: a non-positive exponent flushes to zero.
    flush = !sum_zero && (exp_norm[EXP_W+1] || (exp_norm == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v <= 1'b0;
      s2   <= '0;
    end else if (s2_ld) begin
      s2_v <= s1_v;
      if (s1_v) begin
        // Exact zero is +0 unless two negatives were added.
        s2.sign        <= sum_zero ? (s1.sign & ~s1.eff_sub) : s1.sign;
        s2.exp         <= exp_norm[EXP_W:0];
        s2.sig         <= sig_norm;
        s2.zero        <= sum_zero | flush;
        s2.special     <= s1.special;
        s2.special_res <= s1.special_res;
`ifdef FP_ADD_FLAGS_EN
        s2.uf          <= flush;
`endif
      end
    end
  end

  // ---------------- S3: round to nearest-even and pack ------------------
  logic              round_up, ovf;
  logic [FRAC_W+1:0] mant_rnd;  // {carry, hidden, frac}
  logic [EXP_W:0]    exp_rnd;
  fp32_t             res_nx;

  always_comb begin
    round_up = s2.sig[GUARD] & (s2.sig[ROUND] | s2.sig[STICKY] | s2.sig[GUARD+1]);
    mant_rnd = {1'b0, s2.sig[SIG_W-1:GUARD+1]} + (FRAC_W+2)'(round_up);
    exp_rnd  = s2.exp + {{EXP_W{1'b0}}, mant_rnd[FRAC_W+1]};
    ovf      = (exp_rnd >= (EXP_W+1)'(EXP_INF));

    // On a rounding carry the mantissa is exactly 1.0 x 2, so the low
    // FRAC_W bits are already the (all-zero) renormalized fraction.
    res_nx.sign = s2.sign;
    res_nx.exp  = exp_rnd[EXP_W-1:0];
    res_nx.frac = mant_rnd[FRAC_W-1:0];
    if (s2.special) begin
      res_nx = s2.special_res;
    end else if (s2.zero) begin
      res_nx.exp  = '0;
      res_nx.frac = '0;
    end else if (ovf) begin
      res_nx.exp  = '1;
      res_nx.frac = '0;
    end
  end

`ifdef FP_ADD_FLAGS_EN
  flags_t flags_nx;

  always_comb begin
    flags_nx = '0;
    if (!s2.special) begin
      if (s2.zero) begin
        flags_nx.underflow = s2.uf;
        flags_nx.inexact   = s2.uf;
      end else begin
        flags_nx.overflow = ovf;
        flags_nx.inexact  = ovf | (|s2.sig[GUARD:STICKY]);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_v       <= 1'b0;
      out_result <= '0;
`ifdef FP_ADD_FLAGS_EN
      out_flags  <= '0;
`endif
    end else if (s3_ld) begin
      s3_v <= s2_v;
      if (s2_v) begin
        out_result <= res_nx;
`ifdef FP_ADD_FLAGS_EN
        out_flags  <= flags_nx;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fp_add_normalize_round.sv
// ---------------------------------------------------------------------------
// tb_fp_add_normalize_round
// Directed vectors with hand-derived binary32 results feed a scoreboard
// queue on accept; a negedge monitor pops and compares on every output
// transfer and checks that a stalled output holds steady. Flags are compared
// when FP_ADD_FLAGS_EN is defined.
// ---------------------------------------------------------------------------
module tb_fp_add_normalize_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic        in_sign1, in_sign2;
  logic [7:0]  in_exp;
  logic [26:0] in_sig1, in_sig2;
  logic        in_special;
  logic [31:0] in_special_res;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
`ifdef FP_ADD_FLAGS_EN
  logic [2:0]  out_flags;
`endif

  fp_add_normalize_round dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sign1       (in_sign1),
    .in_sign2       (in_sign2),
    .in_exp         (in_exp),
    .in_sig1        (in_sig1),
    .in_sig2        (in_sig2),
    .in_special     (in_special),
    .in_special_res (in_special_res),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result)
`ifdef FP_ADD_FLAGS_EN
    ,
    .out_flags      (out_flags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  e;
    logic        s1;
    logic        s2;
    logic [26:0] a;
    logic [26:0] b;
    logic        sp;
    logic [31:0] spres;
    logic [31:0] res;
    logic [2:0]  fl;     // {overflow, underflow, inexact}
  } vec_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] res;
    logic [2:0]  fl;
  } exp_t;

  vec_t  vecs[$];
  string vnames[$];
  exp_t  sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  logic        hold_pending = 1'b0;
  logic [31:0] hold_res;

  task automatic add_vec(input string name, input logic [7:0] e, input logic s1,
                         input logic s2, input logic [26:0] a, input logic [26:0] b,
                         input logic sp, input logic [31:0] spres,
                         input logic [31:0] res, input logic [2:0] fl);
    vec_t v;
    v = '{e: e, s1: s1, s2: s2, a: a, b: b, sp: sp, spres: spres, res: res, fl: fl};
    vecs.push_back(v);
    vnames.push_back(name);
  endtask

  // ---------------- output monitor / scoreboard -------------------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        n_checks++;
        if (!out_valid || out_result !== hold_res) begin
          n_fail++;
          $display("FAIL hold_stable: out_valid=%b out_result=%h, required 1 / %h",
                   out_valid, out_result, hold_res);
        end
      end
      hold_pending = 1'b0;
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: out_result=%h, no result was pending", out_result);
        end else begin
          e = sb_q.pop_front();
          if (out_result !== e.res) begin
            n_fail++;
            $display("FAIL %s result: got %h, required %h", vnames[e.id], out_result, e.res);
          end
`ifdef FP_ADD_FLAGS_EN
          n_checks++;
          if (out_flags !== e.fl) begin
            n_fail++;
            $display("FAIL %s flags: got %b, required %b", vnames[e.id], out_flags, e.fl);
          end
`endif
          n_out++;
        end
      end else if (out_valid) begin
        hold_pending = 1'b1;
        hold_res     = out_result;
      end
    end
  end

  // ---------------- driver helpers --------------------------------------
  task automatic apply(input int id);
    in_sign1       = vecs[id].s1;
    in_sign2       = vecs[id].s2;
    in_exp         = vecs[id].e;
    in_sig1        = vecs[id].a;
    in_sig2        = vecs[id].b;
    in_special     = vecs[id].sp;
    in_special_res = vecs[id].spres;
  endtask

  // Present one op, wait (bounded) for acceptance, queue its expectation.
  task automatic send(input int id, output int waited);
    exp_t e;
    waited   = 0;
    in_valid = 1'b1;
    apply(id);
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout %s: in_ready stayed 0", vnames[id]);
    end else begin
      e = '{id: 8'(id), res: vecs[id].res, fl: vecs[id].fl};
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while (sb_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain_timeout: %0d results outstanding, required 0", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  // ---------------- tests -----------------------------------------------
  task automatic test_reset();
    #12;
    n_checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: out_valid=%b out_result=%h, required 0 / 0", out_valid, out_result);
    end
`ifdef FP_ADD_FLAGS_EN
    n_checks++;
    if (out_flags !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 000", out_flags);
    end
`endif
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: in_ready=%b out_valid=%b, required 1 / 0", in_ready, out_valid);
    end
  endtask

  task automatic test_latency();
    exp_t e;
    int   cyc = 0;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_ready: in_ready=%b, required 1", in_ready);
    end
    in_valid = 1'b1;
    apply(0);
    e = '{id: 8'd0, res: vecs[0].res, fl: vecs[0].fl};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_checks++;
    if (cyc != 3) begin
      n_fail++;
      $display("FAIL latency: out_valid after %0d cycles, required 3", cyc);
    end
    wait_drain("latency");
  endtask

  task automatic test_directed();
    int w;
    for (int i = 0; i < vecs.size(); i++) begin
      send(i, w);
      in_valid = 1'b0;
      wait_drain(vnames[i]);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int total = 0;
    int base  = n_out;
    for (int i = 0; i < vecs.size(); i++) begin
      send(i, w);
      total += w;
    end
    in_valid = 1'b0;
    n_checks++;
    if (total != 0) begin
      n_fail++;
      $display("FAIL b2b_stall: %0d stall cycles with out_ready=1, required 0", total);
    end
    wait_drain("b2b");
    n_checks++;
    if (n_out - base != vecs.size()) begin
      n_fail++;
      $display("FAIL b2b_count: %0d results, required %0d", n_out - base, vecs.size());
    end
  endtask

  task automatic test_backpressure();
    logic saw_stall = 1'b0;
    int   base      = n_out;
    fork
      begin
        int w;
        for (int i = 0; i < 6; i++) send(i + 2, w);
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 12; c++) begin
          out_ready = !(c >= 2 && c <= 7);
          @(negedge clk);
          if (in_valid && !in_ready) saw_stall = 1'b1;
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain("backpressure");
    n_checks++;
    if (saw_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_in_ready: in_ready never dropped, required a stall");
    end
    n_checks++;
    if (n_out - base != 6) begin
      n_fail++;
      $display("FAIL bp_count: %0d results, required 6", n_out - base);
    end
  endtask

  task automatic test_reset_midstream();
    int w;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(i, w);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_full: out_valid=%b, required 1", out_valid);
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_clear: out_valid=%b out_result=%h, required 0 / 0", out_valid, out_result);
    end
    sb_q.delete();  // in-flight ops are dropped, not replayed
    out_ready = 1'b1;
    #17 rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_ready: in_ready=%b, required 1", in_ready);
    end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_replay: out_valid=%b, required 0", out_valid);
    end
    send(9, w);
    in_valid = 1'b0;
    wait_drain("midrst_recover");
  endtask

  initial begin
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_sign1       = 1'b0;
    in_sign2       = 1'b0;
    in_exp         = '0;
    in_sig1        = '0;
    in_sig2        = '0;
    in_special     = 1'b0;
    in_special_res = '0;
    out_ready      = 1'b1;

    //       name               exp    s1    s2    sig1        sig2        sp    spres          result        flags
    add_vec("one_plus_one",     8'd127, 1'b0, 1'b0, 27'h4000000, 27'h4000000, 1'b0, 32'h0,        32'h40000000, 3'b000);
    add_vec("one_minus_one",    8'd127, 1'b0, 1'b1, 27'h4000000, 27'h4000000, 1'b0, 32'h0,        32'h00000000, 3'b000);
    add_vec("cancel_lzc23",     8'd127, 1'b0, 1'b1, 27'h4000000, 27'h3FFFFF8, 1'b0, 32'h0,        32'h34000000, 3'b000);
    add_vec("overflow",         8'd254, 1'b0, 1'b0, 27'h6000000, 27'h6000000, 1'b0, 32'h0,        32'h7F800000, 3'b101);
    add_vec("rne_tie_even",     8'd127, 1'b0, 1'b0, 27'h4000000, 27'h0000004, 1'b0, 32'h0,        32'h3F800000, 3'b001);
    add_vec("rne_tie_odd",      8'd127, 1'b0, 1'b0, 27'h4000000, 27'h000000C, 1'b0, 32'h0,        32'h3F800002, 3'b001);
    add_vec("rne_grs101_even",  8'd127, 1'b0, 1'b0, 27'h4000000, 27'h0000005, 1'b0, 32'h0,        32'h3F800001, 3'b001);
    add_vec("rne_grs101_odd",   8'd127, 1'b0, 1'b0, 27'h4000000, 27'h000000D, 1'b0, 32'h0,        32'h3F800002, 3'b001);
    add_vec("neg_diff",         8'd127, 1'b0, 1'b1, 27'h4000000, 27'h6000000, 1'b0, 32'h0,        32'hBF000000, 3'b000);
    add_vec("neg_add",          8'd127, 1'b1, 1'b1, 27'h4000000, 27'h4000000, 1'b0, 32'h0,        32'hC0000000, 3'b000);
    add_vec("neg_zero",         8'd127, 1'b1, 1'b1, 27'h0000000, 27'h0000000, 1'b0, 32'h0,        32'h80000000, 3'b000);
    add_vec("sub_zero_pos",     8'd127, 1'b1, 1'b0, 27'h4000000, 27'h4000000, 1'b0, 32'h0,        32'h00000000, 3'b000);
    add_vec("underflow_neg",    8'd1,   1'b1, 1'b0, 27'h4000000, 27'h3FFFFF8, 1'b0, 32'h0,        32'h80000000, 3'b011);
    add_vec("underflow_exp0",   8'd1,   1'b0, 1'b1, 27'h4000000, 27'h2000000, 1'b0, 32'h0,        32'h00000000, 3'b011);
    add_vec("lowest_normal",    8'd2,   1'b0, 1'b1, 27'h4000000, 27'h2000000, 1'b0, 32'h0,        32'h00800000, 3'b000);
    add_vec("round_carry",      8'd127, 1'b0, 1'b0, 27'h7FFFFF8, 27'h0000004, 1'b0, 32'h0,        32'h40000000, 3'b001);
    add_vec("round_to_inf",     8'd254, 1'b0, 1'b0, 27'h7FFFFF8, 27'h0000004, 1'b0, 32'h0,        32'h7F800000, 3'b101);
    add_vec("carry_round",      8'd127, 1'b0, 1'b0, 27'h4000000, 27'h400000C, 1'b0, 32'h0,        32'h40000001, 3'b001);
    add_vec("carry_sticky",     8'd127, 1'b0, 1'b0, 27'h4000000, 27'h4000003, 1'b0, 32'h0,        32'h40000000, 3'b001);
    add_vec("carry_to_inf",     8'd254, 1'b0, 1'b0, 27'h4000000, 27'h4000000, 1'b0, 32'h0,        32'h7F800000, 3'b101);
    add_vec("special_nan",      8'd127, 1'b0, 1'b0, 27'h4000000, 27'h4000000, 1'b1, 32'h7FC00000, 32'h7FC00000, 3'b000);
    add_vec("special_neg_inf",  8'd254, 1'b0, 1'b0, 27'h6000000, 27'h6000000, 1'b1, 32'hFF800000, 32'hFF800000, 3'b000);

    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
